// File: rtl/mult_sched.sv
// Round-robin scheduler that time-shares one bit-serial neuron x weight multiplier among NUM_REQ requesters.
// 20-cycle handshake-to-response latency; req_ready is only offered in IDLE, so requesters simply wait while a job is in flight.
module mult_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [16*NUM_REQ-1:0] req_neuron,
  input  logic [16*NUM_REQ-1:0] req_weight,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  flush,
  output logic                  mult_reset,
  output logic                  mult_enable,
  output logic [15:0]           mult_neuron,
  output logic                  mult_weight_bit,
  input  logic [15:0]           mult_out,
  output logic                  resp_valid,
  output logic [ID_W-1:0]       resp_id,
  output logic [15:0]           resp_data,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, CAPT} state_t;

  state_t          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] resp_id_q, resp_id_d;
  logic [15:0]     w_q, w_d;
  logic [15:0]     neuron_q, neuron_d;
  logic [15:0]     resp_data_q, resp_data_d;
  logic            resp_valid_q, resp_valid_d;
  logic            mult_reset_q, mult_reset_d;

  logic            hi_found, lo_found, gnt_vld;
  logic [ID_W-1:0] hi_idx, lo_idx, gnt_idx;
  logic [15:0]     sel_neuron, sel_weight;

  // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = ID_W'(i);
        if (ID_W'(i) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(i);
        end
      end
    end
    gnt_idx = hi_found ? hi_idx : lo_idx;
    gnt_vld = reset && (state_q == IDLE) && lo_found;

    req_ready  = '0;
    sel_neuron = '0;
    sel_weight = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == gnt_idx) begin
        req_ready[i] = gnt_vld;
        sel_neuron   = req_neuron[16*i +: 16];
        sel_weight   = req_weight[16*i +: 16];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    w_d          = w_q;
    neuron_d     = neuron_q;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    mult_reset_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          neuron_d = sel_neuron;
          w_d      = sel_weight;
          id_d     = gnt_idx;
          rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          cnt_d    = 5'd0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (cnt_q == 5'd16) begin
          cnt_d   = 5'd0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      DRAIN: state_d = CAPT;
      CAPT: begin
        resp_valid_d = 1'b1;
        resp_id_d    = id_q;
        resp_data_d  = mult_out;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort keeps the advanced pointer and pulses the multiplier's own reset for one cycle.
    if (flush && (state_q != IDLE)) begin
      state_d      = IDLE;
      cnt_d        = 5'd0;
      mult_reset_d = 1'b0;
      resp_valid_d = 1'b0;
      resp_id_d    = resp_id_q;
      resp_data_d  = resp_data_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      w_q          <= '0;
      neuron_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      mult_reset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      w_q          <= w_d;
      neuron_q     <= neuron_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      mult_reset_q <= mult_reset_d;
    end
  end

  // Leading zero, then w[14]..w[0], sign bit last.
  always_comb begin
    mult_weight_bit = 1'b0;
    if (state_q == RUN) begin
      if (cnt_q == 5'd16) begin
        mult_weight_bit = w_q[15];
      end else if (cnt_q != 5'd0) begin
        mult_weight_bit = w_q[4'(5'd15 - cnt_q)];
      end
    end
  end

  assign mult_enable = (state_q == RUN);
  assign busy        = (state_q != IDLE);
  assign mult_neuron = neuron_q;
  assign mult_reset  = mult_reset_q;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_data   = resp_data_q;

endmodule

// File: tb/tb_mult_sched.sv
// Directed bench for mult_sched: single job, round-robin, flush, async reset, dropped request.
module tb_mult_sched;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [16*NUM_REQ-1:0] req_neuron;
  logic [16*NUM_REQ-1:0] req_weight;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  flush;
  logic                  mult_reset;
  logic                  mult_enable;
  logic [15:0]           mult_neuron;
  logic                  mult_weight_bit;
  logic [15:0]           mult_out;
  logic                  resp_valid;
  logic [ID_W-1:0]       resp_id;
  logic [15:0]           resp_data;
  logic                  busy;

  mult_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_neuron      (req_neuron),
    .req_weight      (req_weight),
    .req_ready       (req_ready),
    .flush           (flush),
    .mult_reset      (mult_reset),
    .mult_enable     (mult_enable),
    .mult_neuron     (mult_neuron),
    .mult_weight_bit (mult_weight_bit),
    .mult_out        (mult_out),
    .resp_valid      (resp_valid),
    .resp_id         (resp_id),
    .resp_data       (resp_data),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int last_cyc;
  logic [15:0] seq;
  logic [3:0]  exp_rdy;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [15:0] n, input logic [15:0] w);
    req_neuron[16*i +: 16] = n;
    req_weight[16*i +: 16] = w;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_grant;
    for (int t = 0; t < 40 && req_ready == '0; t++) @(negedge clk);
    chk("grant_timeout", 32'(|req_ready), 32'd1);
  endtask

  task automatic wait_resp;
    for (int t = 0; t < 40 && !resp_valid; t++) @(negedge clk);
    chk("resp_timeout", 32'(resp_valid), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset      = 1'b0;
    req_valid  = '0;
    req_neuron = '0;
    req_weight = '0;
    flush      = 1'b0;
    mult_out   = 16'h1234;

    // Reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_mult_reset", mult_reset, 0);
    chk("rst_enable", mult_enable, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_neuron", mult_neuron, 0);
    @(negedge clk);
    reset = 1'b1;
    nxt;
    chk("rel_mult_reset", mult_reset, 1);

    // Single job on requester 2
    set_req(2, 16'h0C00, 16'hA5F3);
    req_valid = 4'b0100;
    #1;
    chk("t1_ready", req_ready, 4'b0100);
    nxt;
    req_valid = '0;
    chk("t1_en_c0", mult_enable, 1);
    chk("t1_bit_c0", mult_weight_bit, 0);
    chk("t1_busy", busy, 1);
    seq = 16'b0100_1011_1110_0111;
    for (int k = 0; k < 16; k++) begin
      nxt;
      chk($sformatf("t1_bit%0d", k), mult_weight_bit, seq[15-k]);
      chk("t1_en", mult_enable, 1);
      chk("t1_neuron", mult_neuron, 16'h0C00);
    end
    nxt;
    chk("t1_drain_en", mult_enable, 0);
    chk("t1_drain_bit", mult_weight_bit, 0);
    chk("t1_drain_busy", busy, 1);
    nxt;
    chk("t1_capt_rv", resp_valid, 0);
    chk("t1_capt_busy", busy, 1);
    nxt;
    chk("t1_rv", resp_valid, 1);
    chk("t1_id", resp_id, 2);
    chk("t1_data", resp_data, 16'h1234);
    chk("t1_idle_busy", busy, 0);
    chk("t1_neuron_hold", mult_neuron, 16'h0C00);
    nxt;
    chk("t1_rv_pulse", resp_valid, 0);

    // Round-robin with all requesters valid
    do_reset;
    mult_out  = 16'hBEEF;
    req_valid = 4'hF;
    #1;
    for (int g = 0; g < 5; g++) begin
      if (g > 0) nxt;
      wait_grant;
      exp_rdy = 4'b0001 << (g % 4);
      chk($sformatf("t2_ready%0d", g), req_ready, exp_rdy);
      if (g > 0) begin
        chk("t2_spacing", cyc - last_cyc, 20);
        chk("t2_rv", resp_valid, 1);
        chk("t2_id", resp_id, (g - 1) % 4);
        chk("t2_data", resp_data, 16'hBEEF);
      end
      last_cyc = cyc;
    end

    // Flush at cnt 7, then pointer skip 3 then 1
    req_valid = '0;
    do_reset;
    mult_out = 16'h7E57;
    set_req(1, 16'h1111, 16'h0001);
    set_req(3, 16'h3333, 16'h8000);
    req_valid = 4'b0010;
    #1;
    chk("t3_ready1", req_ready, 4'b0010);
    nxt;
    req_valid = 4'b1010;
    #1;
    chk("t3_ready_run", req_ready, 0);
    repeat (7) nxt;
    flush = 1'b1;
    nxt;
    flush = 1'b0;
    chk("t3_mult_reset_lo", mult_reset, 0);
    chk("t3_en_off", mult_enable, 0);
    chk("t3_busy", busy, 0);
    chk("t3_no_rv", resp_valid, 0);
    chk("t3_ready3", req_ready, 4'b1000);
    nxt;
    chk("t3_mult_reset_hi", mult_reset, 1);
    chk("t3_en_on", mult_enable, 1);
    chk("t3_neuron3", mult_neuron, 16'h3333);
    req_valid = 4'b0010;
    wait_resp;
    chk("t3_id", resp_id, 3);
    chk("t3_data", resp_data, 16'h7E57);
    chk("t3_ready_then1", req_ready, 4'b0010);

    // Async reset in the middle of DRAIN
    set_req(0, 16'h0A0A, 16'h5555);
    nxt;
    req_valid = '0;
    repeat (17) nxt;
    chk("t4_drain_busy", busy, 1);
    chk("t4_drain_en", mult_enable, 0);
    req_valid = 4'hF;
    #2;
    reset = 1'b0;
    #1;
    chk("t4_busy", busy, 0);
    chk("t4_mult_reset", mult_reset, 0);
    chk("t4_neuron", mult_neuron, 0);
    chk("t4_ready", req_ready, 0);
    chk("t4_data", resp_data, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t4_first_grant", req_ready, 4'b0001);
    chk("t4_mult_reset_pre", mult_reset, 0);
    nxt;
    req_valid = '0;
    chk("t4_mult_reset_post", mult_reset, 1);
    chk("t4_neuron0", mult_neuron, 16'h0A0A);

    // Request withdrawn before it is ever granted
    req_valid = 4'b0100;
    repeat (3) nxt;
    req_valid = '0;
    wait_resp;
    chk("t5_id", resp_id, 0);
    chk("t5_ready", req_ready, 0);
    chk("t5_busy", busy, 0);
    repeat (3) nxt;
    chk("t5_busy_later", busy, 0);
    chk("t5_no_rv", resp_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
